pcs_tx_code_group: RTL and testbench
====================================

// Module: pcs_tx_code_group
// PURPOSE
//  1000BASE-X PCS transmit code-group generator. It is the peer of the receive Synchronization process.
//  Maps GMII TX_EN/TX_ER/TXD onto a 10-bit code-group stream:
//  - idle ordered sets /I1/,/I2/
//  - packet delimiters /S/,/T/,/R/
//  - data D0.0..D7.0, error /V/
//  Tracks running disparity (RD) and even/odd alignment. Feeds the PMA serializer.
// PARAMETERS
//  none. Code-group constants come from the shared Constants.v include; both RD columns are used.
// PORTS
//  GTX_CLK        in   1   transmit clock, all logic on rising edge
//  mr_main_reset  in   1   synchronous reset, active-low (0 = reset)
//  TX_EN          in   1   GMII transmit enable
//  TX_ER          in   1   GMII transmit error
//  TXD            in   8   GMII transmit octet
//  tx_code_group  out  10  code-group; [9:4]=abcdei, [3:0]=fghj; bit 9 is transmitted first
//  tx_even        out  1   1 = current tx_code_group occupies an even slot
//  tx_disparity   out  1   RD after current code-group (0 = negative, 1 = positive)
//  transmitting   out  1   1 while /S/, data, /V/ or /T/ is being emitted
// BEHAVIOUR
//  Reset (mr_main_reset=0 at edge), all outputs registered:
//  - tx_code_group=10'b0, tx_even=0, tx_disparity=0, transmitting=0, state=TX_IDLE_K
//  Timing:
//  - Inputs sampled at edge n; the resulting code-group is valid after edge n (latency 1).
//  - tx_even toggles every cycle; the first cycle after reset release is even (tx_even=1).
//  RD rule:
//  - Each group is taken from the column of the current RD.
//  - After emission, popcount 6 -> RD+, 4 -> RD-, 5 -> RD unchanged.
//  State machine (one-hot, 7 bits):
//  - TX_IDLE_K (even): emit K28.5, then -> TX_IDLE_D.
//  - TX_IDLE_D (odd): emit D16.2 if RD+ (/I2/), else D5.6 (/I1/). Idle always ends RD-.
//    - TX_EN=1 seen here: the odd idle group still completes; /S/ goes in the next (even) slot.
//      The octet sampled in the TX_IDLE_D cycle is dropped; the octet sampled in the /S/ cycle is also replaced.
//    - Else -> TX_IDLE_K.
//  - TX_IDLE_K with TX_EN=1: emit /S/ (K27.7) in place of the current octet, -> TX_DATA.
//  - TX_DATA with TX_EN=1:
//    - TX_ER=1 -> /V/ (K30.7).
//    - TXD[7:3]==0 -> Dx.0 with x=TXD[2:0].
//    - Any other TXD -> /V/.
//  - TX_DATA with TX_EN=0: emit /T/ (K29.7), -> TX_EOP_R.
//  - TX_EOP_R: emit /R/ (K23.7).
//    - If that /R/ is even, -> TX_EOP_R2.
//    - Else -> TX_IDLE_K.
//  - TX_EOP_R2: emit /R/, -> TX_IDLE_K. Guarantees that K28.5 lands on an even slot.
//  - TX_EN is ignored in TX_EOP_R/TX_EOP_R2; re-assertion is handled from TX_IDLE_K or TX_IDLE_D.
//  - Illegal/unknown state -> TX_IDLE_K with tx_even forced so the next slot is even.
//  - transmitting=1 for /S/, data, /V/ and /T/ cycles; 0 for /R/ and idle.
//  Reset mid-operation: the next edge applies reset values. The stream restarts with K28.5 RD-, tx_even=1.
// STRUCTURE
//  Constants.v (shared include) gains both RD columns for:
//  - K28.5, K27.7, K29.7, K23.7, K30.7
//  - D5.6, D16.2, D0.0..D7.0
//  State one-hot encodings stay local parameters.
//  Sub-module pcs_tx_cg_lookup (combinational):
//  - inputs: octet index and K flag + rd
//  - outputs: 10-bit group, disparity-flip bit
//  - pcs_tx_code_group holds the FSM, tx_even, rd and output registers.
// TESTING
//  1. Hold reset 3 cycles, release, TX_EN=0.
//     -> 0011111010, 1001000101 repeating; tx_even 1,0,1,...; tx_disparity 1,0,...
//  2. TX_EN rises in an even slot, TXD=03h x4 then TX_EN=0.
//     -> 1101101000 (/S/), then D3.0 x3, /T/, /R/, then K28.5; transmitting high /S/../T/.
//  3. TX_EN rises in an odd slot.
//     -> D16.2 completes; /S/ is in the next even slot; the first two octets are absent from the output.
//  4. Packet lengths giving /T/ even vs odd:
//     - /T/ even -> /T/ /R/ K28.5
//     - /T/ odd -> /T/ /R/ /R/ K28.5
//     - K28.5 always has tx_even=1.
//  5. TX_ER=1 for one data cycle, and a separate cycle with TXD=20h -> K30.7 in each; other octets unaffected.
//  6. Reset asserted mid-packet for 1 cycle.
//     -> outputs 0; then K28.5 RD- (0011111010) with tx_even=1.
//     Scoreboard: the receive Synchronization process reaches sync within 3 idle pairs.

Source files
------------

// File: rtl/pcs_tx_code_group_pkg.sv
// Shared 1000BASE-X transmit constants: GMII octet codes, 10-bit code-groups in both
// running-disparity columns, and the disparity helper used by the lookup.
package pcs_tx_code_group_pkg;

  localparam logic [7:0] OCT_K28_5 = 8'hBC;
  localparam logic [7:0] OCT_K27_7 = 8'hFB;
  localparam logic [7:0] OCT_K29_7 = 8'hFD;
  localparam logic [7:0] OCT_K23_7 = 8'hF7;
  localparam logic [7:0] OCT_K30_7 = 8'hFE;
  localparam logic [7:0] OCT_D5_6  = 8'hC5;
  localparam logic [7:0] OCT_D16_2 = 8'h50;

  typedef struct packed {
    logic [9:0] rd_neg;
    logic [9:0] rd_pos;
  } cg_cols_t;

  // Groups are abcdei_fghj with 'a' in bit 9.
  localparam cg_cols_t CG_K28_5 = '{rd_neg: 10'b0011111010, rd_pos: 10'b1100000101};
  localparam cg_cols_t CG_K27_7 = '{rd_neg: 10'b1101101000, rd_pos: 10'b0010010111};
  localparam cg_cols_t CG_K29_7 = '{rd_neg: 10'b1011101000, rd_pos: 10'b0100010111};
  localparam cg_cols_t CG_K23_7 = '{rd_neg: 10'b1110101000, rd_pos: 10'b0001010111};
  localparam cg_cols_t CG_K30_7 = '{rd_neg: 10'b0111101000, rd_pos: 10'b1000010111};
  localparam cg_cols_t CG_D5_6  = '{rd_neg: 10'b1010010110, rd_pos: 10'b1010010110};
  localparam cg_cols_t CG_D16_2 = '{rd_neg: 10'b0110110101, rd_pos: 10'b1001000101};
  localparam cg_cols_t CG_D0_0  = '{rd_neg: 10'b1001110100, rd_pos: 10'b0110001011};
  localparam cg_cols_t CG_D1_0  = '{rd_neg: 10'b0111010100, rd_pos: 10'b1000101011};
  localparam cg_cols_t CG_D2_0  = '{rd_neg: 10'b1011010100, rd_pos: 10'b0100101011};
  localparam cg_cols_t CG_D3_0  = '{rd_neg: 10'b1100011011, rd_pos: 10'b1100010100};
  localparam cg_cols_t CG_D4_0  = '{rd_neg: 10'b1101010100, rd_pos: 10'b0010101011};
  localparam cg_cols_t CG_D5_0  = '{rd_neg: 10'b1010011011, rd_pos: 10'b1010010100};
  localparam cg_cols_t CG_D6_0  = '{rd_neg: 10'b0110011011, rd_pos: 10'b0110010100};
  localparam cg_cols_t CG_D7_0  = '{rd_neg: 10'b1110001011, rd_pos: 10'b0001110100};

  // A group taken from the correct column flips RD exactly when it is unbalanced.
  function automatic logic disparity_flips(input logic [9:0] group);
    logic [3:0] ones;
    ones = 4'd0;
    for (int i = 0; i < 10; i++) begin
      ones = ones + {3'b000, group[i]};
    end
    return (ones != 4'd5);
  endfunction

endpackage

// File: rtl/pcs_tx_code_group_cg_lookup.sv
// Combinational 8b/10b lookup for the small symbol set the transmitter emits:
// picks the column for the current RD and reports whether the group flips RD.
module pcs_tx_cg_lookup
  import pcs_tx_code_group_pkg::*;
(
  input  logic [7:0] octet_i,
  input  logic       k_i,
  input  logic       rd_i,
  output logic [9:0] group_o,
  output logic       flip_o
);

  cg_cols_t cols;

  // Symbol decode; anything outside the supported set becomes /V/ so it reads as an error downstream.
  always_comb begin
    cols = CG_K30_7;
    if (k_i) begin
      case (octet_i)
        OCT_K28_5: cols = CG_K28_5;
        OCT_K27_7: cols = CG_K27_7;
        OCT_K29_7: cols = CG_K29_7;
        OCT_K23_7: cols = CG_K23_7;
        OCT_K30_7: cols = CG_K30_7;
        default:   cols = CG_K30_7;
      endcase
    end else begin
      case (octet_i)
        OCT_D5_6:  cols = CG_D5_6;
        OCT_D16_2: cols = CG_D16_2;
        8'h00:     cols = CG_D0_0;
        8'h01:     cols = CG_D1_0;
        8'h02:     cols = CG_D2_0;
        8'h03:     cols = CG_D3_0;
        8'h04:     cols = CG_D4_0;
        8'h05:     cols = CG_D5_0;
        8'h06:     cols = CG_D6_0;
        8'h07:     cols = CG_D7_0;
        default:   cols = CG_K30_7;
      endcase
    end
    group_o = rd_i ? cols.rd_pos : cols.rd_neg;
    flip_o  = disparity_flips(group_o);
  end

endmodule

// File: rtl/pcs_tx_code_group.sv
// 1000BASE-X PCS transmit code-group generator: GMII TX_EN/TX_ER/TXD to a 10-bit
// stream of idles, /S/ /T/ /R/ delimiters, Dx.0 data and /V/, with RD and even/odd tracking.
module pcs_tx_code_group
  import pcs_tx_code_group_pkg::*;
(
  input  logic       gtx_clk_i,
  input  logic       mr_main_reset_i,
  input  logic       tx_en_i,
  input  logic       tx_er_i,
  input  logic [7:0] txd_i,
  output logic [9:0] tx_code_group_o,
  output logic       tx_even_o,
  output logic       tx_disparity_o,
  output logic       transmitting_o
);

  localparam logic [6:0] ST_IDLE_K  = 7'b0000001;
  localparam logic [6:0] ST_IDLE_D  = 7'b0000010;
  localparam logic [6:0] ST_START   = 7'b0000100;
  localparam logic [6:0] ST_DATA    = 7'b0001000;
  localparam logic [6:0] ST_EOP_R   = 7'b0010000;
  localparam logic [6:0] ST_EOP_R2  = 7'b0100000;

  logic [6:0] state_q, state_d;
  logic       even_q, even_d;
  logic       rd_q;
  logic [9:0] cg_q;
  logic       tx_q, tx_d;
  logic       sym_k;
  logic [7:0] sym_octet;
  logic [9:0] group;
  logic       flip;

  pcs_tx_cg_lookup u_lookup (
    .octet_i (sym_octet),
    .k_i     (sym_k),
    .rd_i    (rd_q),
    .group_o (group),
    .flip_o  (flip)
  );

  // Next-symbol selection; even_d is the parity of the slot being produced this cycle.
  always_comb begin
    state_d   = state_q;
    even_d    = ~even_q;
    tx_d      = 1'b0;
    sym_k     = 1'b1;
    sym_octet = OCT_K28_5;
    case (state_q)
      ST_IDLE_K: begin
        if (tx_en_i) begin
          sym_octet = OCT_K27_7;
          tx_d      = 1'b1;
          state_d   = ST_DATA;
        end else begin
          sym_octet = OCT_K28_5;
          state_d   = ST_IDLE_D;
        end
      end
      ST_IDLE_D: begin
        // D16.2 from RD+ and D5.6 from RD- both leave the link at RD-.
        sym_k     = 1'b0;
        sym_octet = rd_q ? OCT_D16_2 : OCT_D5_6;
        if (tx_en_i) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE_K;
        end
      end
      ST_START: begin
        sym_octet = OCT_K27_7;
        tx_d      = 1'b1;
        state_d   = ST_DATA;
      end
      ST_DATA: begin
        tx_d = 1'b1;
        if (!tx_en_i) begin
          sym_octet = OCT_K29_7;
          state_d   = ST_EOP_R;
        end else if (tx_er_i || (txd_i[7:3] != 5'b00000)) begin
          sym_octet = OCT_K30_7;
        end else begin
          sym_k     = 1'b0;
          sym_octet = {5'b00000, txd_i[2:0]};
        end
      end
      ST_EOP_R: begin
        sym_octet = OCT_K23_7;
        if (even_d) begin
          state_d = ST_EOP_R2;
        end else begin
          state_d = ST_IDLE_K;
        end
      end
      ST_EOP_R2: begin
        sym_octet = OCT_K23_7;
        state_d   = ST_IDLE_K;
      end
      default: begin
        sym_k     = 1'b0;
        sym_octet = rd_q ? OCT_D16_2 : OCT_D5_6;
        even_d    = 1'b0;
        state_d   = ST_IDLE_K;
      end
    endcase
  end

  // State, alignment, running disparity and registered outputs.
  always_ff @(posedge gtx_clk_i) begin
    if (!mr_main_reset_i) begin
      state_q <= ST_IDLE_K;
      even_q  <= 1'b0;
      rd_q    <= 1'b0;
      cg_q    <= 10'b0000000000;
      tx_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      even_q  <= even_d;
      rd_q    <= rd_q ^ flip;
      cg_q    <= group;
      tx_q    <= tx_d;
    end
  end

  assign tx_code_group_o = cg_q;
  assign tx_even_o       = even_q;
  assign tx_disparity_o  = rd_q;
  assign transmitting_o  = tx_q;

endmodule

// File: tb/tb_pcs_tx_code_group.sv
// Bench for pcs_tx_code_group: vector table plus hand-written sequences, expectations
// queued when driven and checked one cycle later, with a comma-on-even-slot check.
module tb_pcs_tx_code_group;

  localparam logic [9:0] K285N = 10'b0011111010;
  localparam logic [9:0] K285P = 10'b1100000101;
  localparam logic [9:0] D162P = 10'b1001000101;
  localparam logic [9:0] D56   = 10'b1010010110;
  localparam logic [9:0] S_N   = 10'b1101101000;
  localparam logic [9:0] T_N   = 10'b1011101000;
  localparam logic [9:0] T_P   = 10'b0100010111;
  localparam logic [9:0] R_N   = 10'b1110101000;
  localparam logic [9:0] R_P   = 10'b0001010111;
  localparam logic [9:0] V_N   = 10'b0111101000;
  localparam logic [9:0] V_P   = 10'b1000010111;
  localparam logic [9:0] D0N   = 10'b1001110100;
  localparam logic [9:0] D0P   = 10'b0110001011;
  localparam logic [9:0] D1N   = 10'b0111010100;
  localparam logic [9:0] D2N   = 10'b1011010100;
  localparam logic [9:0] D2P   = 10'b0100101011;
  localparam logic [9:0] D3N   = 10'b1100011011;
  localparam logic [9:0] D3P   = 10'b1100010100;
  localparam logic [9:0] D4N   = 10'b1101010100;
  localparam logic [9:0] D5N   = 10'b1010011011;
  localparam logic [9:0] D6P   = 10'b0110010100;
  localparam logic [9:0] D7N   = 10'b1110001011;

  logic       clk = 1'b0;
  logic       rst_n, en, er;
  logic [7:0] txd;
  logic [9:0] cg;
  logic       even, disp, txing;

  typedef struct packed {
    logic [9:0] cg;
    logic       even;
    logic       disp;
    logic       tx;
  } out_t;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       en;
    logic       er;
    logic [7:0] txd;
    out_t       exp;
  } vec_t;

  out_t exp_q[$];
  vec_t vecs[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  pcs_tx_code_group dut (
    .gtx_clk_i       (clk),
    .mr_main_reset_i (rst_n),
    .tx_en_i         (en),
    .tx_er_i         (er),
    .txd_i           (txd),
    .tx_code_group_o (cg),
    .tx_even_o       (even),
    .tx_disparity_o  (disp),
    .transmitting_o  (txing)
  );

  function automatic void add(input string name, input logic r, input logic e, input logic x,
                              input logic [7:0] d, input logic [9:0] ecg, input logic ev,
                              input logic ds, input logic t);
    vec_t v;
    v.name  = name;
    v.rst_n = r;
    v.en    = e;
    v.er    = x;
    v.txd   = d;
    v.exp   = '{cg: ecg, even: ev, disp: ds, tx: t};
    vecs.push_back(v);
  endfunction

  task automatic step(input string name, input logic r, input logic e, input logic x,
                      input logic [7:0] d, input logic [9:0] ecg, input logic ev,
                      input logic ds, input logic t);
    out_t want, got;
    rst_n = r;
    en    = e;
    er    = x;
    txd   = d;
    exp_q.push_back('{cg: ecg, even: ev, disp: ds, tx: t});
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    got  = '{cg: cg, even: even, disp: disp, tx: txing};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got cg=%b even=%b disp=%b tx=%b, want cg=%b even=%b disp=%b tx=%b",
               name, got.cg, got.even, got.disp, got.tx, want.cg, want.even, want.disp, want.tx);
    end
    if (cg === K285N || cg === K285P) begin
      total++;
      if (even !== 1'b1) begin
        bad++;
        $display("FAIL %s comma_slot: got tx_even=%b, want 1", name, even);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    er    = 1'b0;
    txd   = 8'h00;

    // Reset then idle pairs from RD-.
    for (int i = 0; i < 3; i++) add("reset", 1'b0, 1'b0, 1'b0, 8'h00, 10'b0000000000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      add("idle_k", 1'b1, 1'b0, 1'b0, 8'h00, K285N, 1'b1, 1'b1, 1'b0);
      add("idle_d", 1'b1, 1'b0, 1'b0, 8'h00, D162P, 1'b0, 1'b0, 1'b0);
    end
    // Packet starting on an even slot, /T/ even.
    add("pkt_s",   1'b1, 1'b1, 1'b0, 8'h03, S_N,   1'b1, 1'b0, 1'b1);
    add("pkt_d1",  1'b1, 1'b1, 1'b0, 8'h03, D3N,   1'b0, 1'b1, 1'b1);
    add("pkt_d2",  1'b1, 1'b1, 1'b0, 8'h03, D3P,   1'b1, 1'b0, 1'b1);
    add("pkt_d3",  1'b1, 1'b1, 1'b0, 8'h03, D3N,   1'b0, 1'b1, 1'b1);
    add("pkt_t",   1'b1, 1'b0, 1'b0, 8'h03, T_P,   1'b1, 1'b1, 1'b1);
    add("pkt_r",   1'b1, 1'b0, 1'b0, 8'h00, R_P,   1'b0, 1'b1, 1'b0);
    add("pkt_k",   1'b1, 1'b0, 1'b0, 8'h00, K285P, 1'b1, 1'b0, 1'b0);
    add("pkt_i1",  1'b1, 1'b0, 1'b0, 8'h00, D56,   1'b0, 1'b0, 1'b0);
    // /T/ odd: two /R/, TX_EN ignored while they go out.
    add("odd_s",   1'b1, 1'b1, 1'b0, 8'h00, S_N,   1'b1, 1'b0, 1'b1);
    add("odd_d1",  1'b1, 1'b1, 1'b0, 8'h01, D1N,   1'b0, 1'b0, 1'b1);
    add("odd_d7",  1'b1, 1'b1, 1'b0, 8'h07, D7N,   1'b1, 1'b1, 1'b1);
    add("odd_t",   1'b1, 1'b0, 1'b0, 8'h00, T_P,   1'b0, 1'b1, 1'b1);
    add("odd_r1",  1'b1, 1'b1, 1'b0, 8'h55, R_P,   1'b1, 1'b1, 1'b0);
    add("odd_r2",  1'b1, 1'b1, 1'b0, 8'h55, R_P,   1'b0, 1'b1, 1'b0);
    add("odd_k",   1'b1, 1'b0, 1'b0, 8'h00, K285P, 1'b1, 1'b0, 1'b0);
    add("odd_i1",  1'b1, 1'b0, 1'b0, 8'h00, D56,   1'b0, 1'b0, 1'b0);
    // Error handling: TX_ER and an out-of-range octet each give /V/.
    add("err_s",   1'b1, 1'b1, 1'b0, 8'h00, S_N,   1'b1, 1'b0, 1'b1);
    add("err_d0",  1'b1, 1'b1, 1'b0, 8'h00, D0N,   1'b0, 1'b0, 1'b1);
    add("err_er",  1'b1, 1'b1, 1'b1, 8'h03, V_N,   1'b1, 1'b0, 1'b1);
    add("err_d3",  1'b1, 1'b1, 1'b0, 8'h03, D3N,   1'b0, 1'b1, 1'b1);
    add("err_20",  1'b1, 1'b1, 1'b0, 8'h20, V_P,   1'b1, 1'b1, 1'b1);
    add("err_d0p", 1'b1, 1'b1, 1'b0, 8'h00, D0P,   1'b0, 1'b1, 1'b1);
    add("err_d2p", 1'b1, 1'b1, 1'b0, 8'h02, D2P,   1'b1, 1'b1, 1'b1);
    add("err_ff",  1'b1, 1'b1, 1'b0, 8'hFF, V_P,   1'b0, 1'b1, 1'b1);
    add("err_t",   1'b1, 1'b0, 1'b0, 8'h00, T_P,   1'b1, 1'b1, 1'b1);
    add("err_r",   1'b1, 1'b0, 1'b0, 8'h00, R_P,   1'b0, 1'b1, 1'b0);
    add("err_k",   1'b1, 1'b0, 1'b0, 8'h00, K285P, 1'b1, 1'b0, 1'b0);
    add("err_i1",  1'b1, 1'b0, 1'b0, 8'h00, D56,   1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].name, vecs[i].rst_n, vecs[i].en, vecs[i].er, vecs[i].txd,
           vecs[i].exp.cg, vecs[i].exp.even, vecs[i].exp.disp, vecs[i].exp.tx);
    end

    // TX_EN rising in an odd slot: octets AA and BB never appear.
    step("late_k",  1'b1, 1'b0, 1'b0, 8'h00, K285N, 1'b1, 1'b1, 1'b0);
    step("late_i2", 1'b1, 1'b1, 1'b0, 8'hAA, D162P, 1'b0, 1'b0, 1'b0);
    step("late_s",  1'b1, 1'b1, 1'b0, 8'hBB, S_N,   1'b1, 1'b0, 1'b1);
    step("late_d2", 1'b1, 1'b1, 1'b0, 8'h02, D2N,   1'b0, 1'b0, 1'b1);
    step("late_d4", 1'b1, 1'b1, 1'b0, 8'h04, D4N,   1'b1, 1'b0, 1'b1);
    step("late_d5", 1'b1, 1'b1, 1'b0, 8'h05, D5N,   1'b0, 1'b1, 1'b1);
    step("late_d6", 1'b1, 1'b1, 1'b0, 8'h06, D6P,   1'b1, 1'b0, 1'b1);
    step("late_t",  1'b1, 1'b0, 1'b0, 8'h00, T_N,   1'b0, 1'b0, 1'b1);
    step("late_r1", 1'b1, 1'b0, 1'b0, 8'h00, R_N,   1'b1, 1'b0, 1'b0);
    step("late_r2", 1'b1, 1'b0, 1'b0, 8'h00, R_N,   1'b0, 1'b0, 1'b0);
    step("late_k2", 1'b1, 1'b0, 1'b0, 8'h00, K285N, 1'b1, 1'b1, 1'b0);
    step("late_i3", 1'b1, 1'b0, 1'b0, 8'h00, D162P, 1'b0, 1'b0, 1'b0);

    // One-cycle reset in the middle of a packet.
    step("mid_s",   1'b1, 1'b1, 1'b0, 8'h03, S_N,   1'b1, 1'b0, 1'b1);
    step("mid_d3",  1'b1, 1'b1, 1'b0, 8'h03, D3N,   1'b0, 1'b1, 1'b1);
    step("mid_rst", 1'b0, 1'b1, 1'b0, 8'h03, 10'b0000000000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("mid_k", 1'b1, 1'b0, 1'b0, 8'h00, K285N, 1'b1, 1'b1, 1'b0);
      step("mid_d", 1'b1, 1'b0, 1'b0, 8'h00, D162P, 1'b0, 1'b0, 1'b0);
    end

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
